// File: rtl/jtpopeye_sec_pkg.sv
// Shared types and constants for the Popeye security-device sequencer.
// Build option: SEC_CTX_RESTORE_EN adds CPU context replay after aux transactions.
package jtpopeye_sec_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_LO   = 4'd1,
        ST_W_HI   = 4'd2,
        ST_W_SH   = 4'd3,
        ST_SETTLE = 4'd4,
        ST_RD     = 4'd5,
        ST_CAP    = 4'd6,
        ST_R_LO   = 4'd7,
        ST_R_HI   = 4'd8,
        ST_R_SH   = 4'd9,
        ST_R_SET  = 4'd10
    } sec_state_e;

    localparam logic A0_DATA  = 1'b1;
    localparam logic A0_SHIFT = 1'b0;

    // Longest aux transaction in cen periods (six base states plus four replay states)
    localparam int MAX_TXN_LEN = 10;

    typedef struct packed {
        logic       cs;
        logic       a0;
        logic       rd_n;
        logic       wr_n;
        logic [7:0] din;
    } sec_bus_t;

    localparam sec_bus_t BUS_IDLE = '{cs: 1'b0, a0: 1'b0, rd_n: 1'b1, wr_n: 1'b1, din: 8'h00};

    function automatic sec_bus_t bus_write(input logic a0, input logic [7:0] data);
        sec_bus_t b;
        b = '{cs: 1'b1, a0: a0, rd_n: 1'b1, wr_n: 1'b0, din: data};
        return b;
    endfunction

    function automatic sec_bus_t bus_read(input logic a0);
        sec_bus_t b;
        b = '{cs: 1'b1, a0: a0, rd_n: 1'b0, wr_n: 1'b1, din: 8'h00};
        return b;
    endfunction

endpackage

// File: rtl/jtpopeye_sec_ctrl.sv
// Arbiter/sequencer sharing the Popeye protection shifter between the CPU and an aux requester.
// Build option: define SEC_CTX_RESTORE_EN to replay the CPU's device context after each aux run.
module jtpopeye_sec_ctrl
    import jtpopeye_sec_pkg::*;
#(
    parameter bit AUX_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cpu_cs,
    input  logic       cpu_a0,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_wait_n,
    input  logic       aux_req,
    input  logic [7:0] aux_hi,
    input  logic [7:0] aux_lo,
    input  logic [2:0] aux_shift,
    output logic       aux_busy,
    output logic       aux_ack,
    output logic [7:0] aux_result,
    output logic       sec_cs,
    output logic       sec_a0,
    output logic       sec_rd_n,
    output logic       sec_wr_n,
    output logic [7:0] sec_din,
    input  logic [7:0] sec_dout
);

    sec_state_e state_q, state_d;
    logic [7:0] op_hi_q, op_hi_d;
    logic [7:0] op_lo_q, op_lo_d;
    logic [2:0] op_sh_q, op_sh_d;
    logic [7:0] aux_result_q, aux_result_d;
    logic       aux_ack_q, aux_ack_d;
    logic       cpu_active_s;
    logic       aux_wins_s;
    logic       start_s;
    sec_bus_t   bus_s;

`ifdef SEC_CTX_RESTORE_EN
    logic [7:0] sh_lo_q, sh_lo_d;
    logic [7:0] sh_hi_q, sh_hi_d;
    logic [2:0] sh_shift_q, sh_shift_d;
`endif

    assign cpu_active_s = cpu_cs & (~cpu_rd_n | ~cpu_wr_n);
    assign aux_wins_s   = aux_req & cpu_active_s & AUX_PRIO;
    assign start_s      = aux_req & (~cpu_active_s | AUX_PRIO);

    // Next-state, operand latch and result capture
    always_comb begin
        state_d      = state_q;
        op_hi_d      = op_hi_q;
        op_lo_d      = op_lo_q;
        op_sh_d      = op_sh_q;
        aux_result_d = aux_result_q;
        aux_ack_d    = 1'b0;
        if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        op_hi_d = aux_hi;
                        op_lo_d = aux_lo;
                        op_sh_d = aux_shift;
                        state_d = ST_W_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_W_LO:   state_d = ST_W_HI;
                ST_W_HI:   state_d = ST_W_SH;
                ST_W_SH:   state_d = ST_SETTLE;
                ST_SETTLE: state_d = ST_RD;
                ST_RD: begin
                    aux_result_d = sec_dout;
                    aux_ack_d    = 1'b1;
                    state_d      = ST_CAP;
                end
`ifdef SEC_CTX_RESTORE_EN
                ST_CAP:    state_d = ST_R_LO;
                ST_R_LO:   state_d = ST_R_HI;
                ST_R_HI:   state_d = ST_R_SH;
                ST_R_SH:   state_d = ST_R_SET;
                ST_R_SET:  state_d = ST_IDLE;
`else
                ST_CAP:    state_d = ST_IDLE;
`endif
                default:   state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

`ifdef SEC_CTX_RESTORE_EN
    // Shadow the device state built up by CPU writes that actually reach the device
    always_comb begin
        sh_lo_d    = sh_lo_q;
        sh_hi_d    = sh_hi_q;
        sh_shift_d = sh_shift_q;
        if (cen && (state_q == ST_IDLE) && cpu_cs && !cpu_wr_n && !aux_wins_s) begin
            if (cpu_a0 == A0_DATA) begin
                sh_lo_d = sh_hi_q;
                sh_hi_d = cpu_din;
            end else begin
                sh_shift_d = cpu_din[2:0];
            end
        end else begin
            sh_shift_d = sh_shift_q;
        end
    end

    // Shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_lo_q    <= 8'h00;
            sh_hi_q    <= 8'h00;
            sh_shift_q <= 3'd0;
        end else begin
            sh_lo_q    <= sh_lo_d;
            sh_hi_q    <= sh_hi_d;
            sh_shift_q <= sh_shift_d;
        end
    end
`endif

    // Device bus encoding: CPU pass-through in IDLE, sequenced cycles otherwise
    always_comb begin
        bus_s = BUS_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (aux_wins_s) begin
                    bus_s = BUS_IDLE;
                end else begin
                    bus_s = '{cs: cpu_cs, a0: cpu_a0, rd_n: cpu_rd_n, wr_n: cpu_wr_n, din: cpu_din};
                end
            end
            ST_W_LO:   bus_s = bus_write(A0_DATA, op_lo_q);
            ST_W_HI:   bus_s = bus_write(A0_DATA, op_hi_q);
            ST_W_SH:   bus_s = bus_write(A0_SHIFT, {5'b00000, op_sh_q});
            ST_SETTLE: bus_s = BUS_IDLE;
            ST_RD:     bus_s = bus_read(A0_SHIFT);
            ST_CAP:    bus_s = BUS_IDLE;
`ifdef SEC_CTX_RESTORE_EN
            ST_R_LO:   bus_s = bus_write(A0_DATA, sh_lo_q);
            ST_R_HI:   bus_s = bus_write(A0_DATA, sh_hi_q);
            ST_R_SH:   bus_s = bus_write(A0_SHIFT, {5'b00000, sh_shift_q});
            ST_R_SET:  bus_s = BUS_IDLE;
`endif
            default:   bus_s = BUS_IDLE;
        endcase
    end

    // Sequencer state and aux result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_hi_q      <= 8'h00;
            op_lo_q      <= 8'h00;
            op_sh_q      <= 3'd0;
            aux_result_q <= 8'h00;
            aux_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_hi_q      <= op_hi_d;
            op_lo_q      <= op_lo_d;
            op_sh_q      <= op_sh_d;
            aux_result_q <= aux_result_d;
            aux_ack_q    <= aux_ack_d;
        end
    end

    assign sec_cs     = bus_s.cs;
    assign sec_a0     = bus_s.a0;
    assign sec_rd_n   = bus_s.rd_n;
    assign sec_wr_n   = bus_s.wr_n;
    assign sec_din    = bus_s.din;
    assign cpu_dout   = sec_dout;
    assign aux_busy   = (state_q != ST_IDLE);
    assign aux_ack    = aux_ack_q;
    assign aux_result = aux_result_q;
    // In IDLE a stall only happens when aux wins a collision; otherwise any CPU strobe stalls
    assign cpu_wait_n = (state_q == ST_IDLE) ? ~aux_wins_s : ~cpu_active_s;

endmodule

// File: tb/tb_jtpopeye_sec_ctrl.sv
// Scoreboard bench for jtpopeye_sec_ctrl with a behavioural Popeye shifter on the device bus.
module tb_jtpopeye_sec_ctrl;

    logic       clk = 1'b0;
    logic       rst, cen;
    logic       cpu_cs, cpu_a0, cpu_rd_n, cpu_wr_n;
    logic [7:0] cpu_din, cpu_dout;
    logic       cpu_wait_n;
    logic       aux_req;
    logic [7:0] aux_hi, aux_lo;
    logic [2:0] aux_shift;
    logic       aux_busy, aux_ack;
    logic [7:0] aux_result;
    logic       sec_cs, sec_a0, sec_rd_n, sec_wr_n;
    logic [7:0] sec_din, sec_dout;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    logic [7:0] dev_old, dev_new, dev_res;
    logic [2:0] dev_sh;

    jtpopeye_sec_ctrl dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_cs(cpu_cs), .cpu_a0(cpu_a0), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
        .aux_req(aux_req), .aux_hi(aux_hi), .aux_lo(aux_lo), .aux_shift(aux_shift),
        .aux_busy(aux_busy), .aux_ack(aux_ack), .aux_result(aux_result),
        .sec_cs(sec_cs), .sec_a0(sec_a0), .sec_rd_n(sec_rd_n), .sec_wr_n(sec_wr_n),
        .sec_din(sec_din), .sec_dout(sec_dout)
    );

    always #5 clk = ~clk;

    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cen = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic int expected_shift(input int h, input int l, input int s);
        if (s == 0) return h;
        return ((h << s) | (l >> (8 - s))) % 256;
    endfunction

    // Device model: two-byte FIFO of a0=1 writes, shift from a0=0 writes, registered 16-bit shift
    always @(posedge clk) begin
        if (rst) begin
            dev_old <= 8'h00; dev_new <= 8'h00; dev_sh <= 3'd0; dev_res <= 8'h00;
        end else if (cen) begin
            if (sec_cs && !sec_wr_n) begin
                if (sec_a0) begin
                    dev_old <= dev_new;
                    dev_new <= sec_din;
                end else begin
                    dev_sh <= sec_din[2:0];
                end
            end
            dev_res <= 8'((((int'(dev_new) * 256) + int'(dev_old)) << dev_sh) / 256);
        end
    end
    assign sec_dout = dev_res;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on ack; stall and read-data rules checked every cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (aux_ack) begin
                if (exp_q.size() == 0) check("unexpected_ack", 1, 0);
                else check("aux_result", int'(aux_result), exp_q.pop_front());
            end
            if (aux_busy)
                check("wait_n_busy", int'(cpu_wait_n),
                      (cpu_cs && (!cpu_rd_n || !cpu_wr_n)) ? 0 : 1);
            if (sec_cs && !sec_rd_n) check("cpu_dout", int'(cpu_dout), int'(dev_res));
        end
    end

    task automatic wait_cen(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            do begin
                @(posedge clk);
                k++;
            end while (!cen && k < 100);
        end
        #1;
    endtask

    task automatic start_aux(input logic [7:0] h, input logic [7:0] l, input logic [2:0] s,
                             input bit expect_ack);
        if (expect_ack) exp_q.push_back(expected_shift(h, l, s));
        aux_hi = h; aux_lo = l; aux_shift = s; aux_req = 1'b1;
        wait_cen(1);
        aux_req = 1'b0;
        aux_hi = 8'($urandom); aux_lo = 8'($urandom); aux_shift = 3'($urandom);
        check("busy_after_start", int'(aux_busy), 1);
    endtask

    task automatic finish_aux(input int edges);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            if (cen) edges++;
            #1;
            got = aux_ack;
        end
        check("ack_seen", int'(got), 1);
        check("ack_latency", edges, 6);
        for (int i = 0; i < 300 && aux_busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("busy_cleared", int'(aux_busy), 0);
    endtask

    task automatic run_aux(input logic [7:0] h, input logic [7:0] l, input logic [2:0] s);
        start_aux(h, l, s, 1'b1);
        finish_aux(1);
    endtask

    task automatic cpu_write(input logic a0, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_a0 = a0; cpu_wr_n = 1'b0; cpu_din = d;
        wait_cen(1);
        cpu_cs = 1'b0; cpu_wr_n = 1'b1; cpu_din = 8'h00; cpu_a0 = 1'b0;
    endtask

    task automatic cpu_read_check(input string name, input logic a0, input int exp);
        cpu_cs = 1'b1; cpu_a0 = a0; cpu_rd_n = 1'b0;
        #1;
        check(name, int'(cpu_dout), exp);
        wait_cen(1);
        cpu_cs = 1'b0; cpu_rd_n = 1'b1; cpu_a0 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sec_cs"}, int'(sec_cs), 0);
        check({tag, "_sec_a0"}, int'(sec_a0), 0);
        check({tag, "_sec_rd_n"}, int'(sec_rd_n), 1);
        check({tag, "_sec_wr_n"}, int'(sec_wr_n), 1);
        check({tag, "_sec_din"}, int'(sec_din), 0);
        check({tag, "_aux_busy"}, int'(aux_busy), 0);
        check({tag, "_aux_ack"}, int'(aux_ack), 0);
        check({tag, "_aux_result"}, int'(aux_result), 0);
        check({tag, "_cpu_wait_n"}, int'(cpu_wait_n), 1);
    endtask

    initial begin
        logic [7:0] h, l;
        logic [2:0] s;
        rst = 1'b1;
        cpu_cs = 1'b0; cpu_a0 = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_din = 8'h00;
        aux_req = 1'b0; aux_hi = 8'h00; aux_lo = 8'h00; aux_shift = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cen(2);

        // Directed operand sets
        run_aux(8'hA5, 8'h3C, 3'd3);
        run_aux(8'h5A, 8'hFF, 3'd0);
        run_aux(8'h80, 8'h01, 3'd7);

        // Randomized operands
        for (int i = 0; i < 16; i++) begin
            h = 8'($urandom); l = 8'($urandom); s = 3'($urandom);
            run_aux(h, l, s);
`ifndef SEC_CTX_RESTORE_EN
            if (i < 4) cpu_read_check("dev_after_aux", 1'b0, expected_shift(h, l, s));
`endif
        end

        // CPU shift write issued while the sequencer is in W_HI
        start_aux(8'h12, 8'h34, 3'd5, 1'b1);
        wait_cen(1);
        cpu_cs = 1'b1; cpu_a0 = 1'b0; cpu_wr_n = 1'b0; cpu_din = 8'h03;
        #1;
        check("stall_in_w_hi", int'(cpu_wait_n), 0);
        finish_aux(2);
        check("wait_n_released", int'(cpu_wait_n), 1);
        check("pass_cs", int'(sec_cs), 1);
        check("pass_a0", int'(sec_a0), 0);
        check("pass_wr_n", int'(sec_wr_n), 0);
        check("pass_din", int'(sec_din), 8'h03);
        wait_cen(1);
        cpu_cs = 1'b0; cpu_wr_n = 1'b1; cpu_din = 8'h00;
        check("dev_shift_written", int'(dev_sh), 3);

        // Same-cycle collision: the CPU keeps the device until its strobe releases
        cpu_cs = 1'b1; cpu_a0 = 1'b1; cpu_rd_n = 1'b0;
        exp_q.push_back(expected_shift(8'hC3, 8'h99, 3'd2));
        aux_hi = 8'hC3; aux_lo = 8'h99; aux_shift = 3'd2; aux_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cen(1);
            check("coll_busy", int'(aux_busy), 0);
            check("coll_wait_n", int'(cpu_wait_n), 1);
            check("coll_pass_rd", int'(sec_cs && !sec_rd_n), 1);
        end
        cpu_cs = 1'b0; cpu_rd_n = 1'b1; cpu_a0 = 1'b0;
        wait_cen(1);
        check("coll_start_after_release", int'(aux_busy), 1);
        aux_req = 1'b0;
        finish_aux(1);

        // Reset while the sequencer is in RD aborts without an ack
        start_aux(8'hF0, 8'h0F, 3'd4, 1'b0);
        wait_cen(4);
        check("in_rd_state", int'(sec_cs && !sec_rd_n), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        rst = 1'b0;
        wait_cen(4);
        run_aux(8'h3C, 8'hA5, 3'd1);

`ifdef SEC_CTX_RESTORE_EN
        // CPU context must survive an aux transaction
        cpu_write(1'b1, 8'h11);
        cpu_write(1'b1, 8'h22);
        cpu_write(1'b0, 8'h04);
        wait_cen(2);
        cpu_read_check("ctx_before_aux", 1'b0, 8'h21);
        run_aux(8'($urandom), 8'($urandom), 3'($urandom));
        cpu_read_check("ctx_after_aux", 1'b0, 8'h21);
`else
        cpu_write(1'b1, 8'h11);
        cpu_write(1'b1, 8'h22);
        cpu_write(1'b0, 8'h04);
        wait_cen(2);
        cpu_read_check("cpu_direct_read", 1'b0, 8'h21);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtpopeye_sec_ctrl.md
Name: jtpopeye_sec_ctrl

Overview:
- Sequencer and arbiter in front of the Popeye protection barrel-shifter (two-byte FIFO plus 3-bit shift, registered result; all accesses qualified by `cen`).
- Shares the shifter between the main CPU bus and an auxiliary requester (self-test / attract-mode checker).
- Runs the aux request as an atomic write-write-shift-read transaction.
- Stalls the CPU with `cpu_wait_n` while an aux transaction owns the device.

Parameters:
- AUX_PRIO, 0: 0 = CPU wins a same-cycle collision in IDLE; 1 = aux wins.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  device clock enable; all state advances only on clk edges with cen=1
- cpu_cs  in  1  CPU selects security device
- cpu_a0  in  1  CPU address bit 0
- cpu_rd_n  in  1  CPU read strobe
- cpu_wr_n  in  1  CPU write strobe
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  read data to CPU
- cpu_wait_n  out  1  low = CPU access stalled
- aux_req  in  1  level request; operands sampled at start
- aux_hi  in  8  byte shifted left
- aux_lo  in  8  byte shifted right
- aux_shift  in  3  shift amount
- aux_busy  out  1  transaction in progress
- aux_ack  out  1  one-clk pulse, result valid
- aux_result  out  8  captured result, held until next ack
- sec_cs, sec_a0, sec_rd_n, sec_wr_n  out  1 each  device bus
- sec_din  out  8  device write data
- sec_dout  in  8  device read data

Behaviour:
- Reset values:
  - `sec_cs`=0, `sec_rd_n`=`sec_wr_n`=1, `sec_a0`=0, `sec_din`=0
  - `aux_busy`=0, `aux_ack`=0, `aux_result`=0, `cpu_wait_n`=1
  - FSM returns to IDLE.
- Reset mid-transaction aborts without an ack.
- `cpu_dout` equals `sec_dout` combinationally at all times.
- IDLE:
  - `sec_*` follow `cpu_*` combinationally (pass-through); `cpu_wait_n`=1.
  - On a cen edge with `aux_req`=1, start only if no CPU access is active (`cpu_cs`=1 with rd or wr low).
  - If a CPU access is active, resolve by AUX_PRIO. When aux wins, `cpu_wait_n`=0 that same cycle.
  - On start, latch `aux_hi`, `aux_lo`, `aux_shift` and go to W_LO.
- Aux states: each holds exactly one cen period, advances on the next cen.
  - W_LO: cs=1, a0=1, wr_n=0, din=lo.
  - W_HI: cs=1, a0=1, wr_n=0, din=hi.
  - W_SH: cs=1, a0=0, wr_n=0, din={5'b0, shift}.
  - SETTLE: cs=0 (device registers result).
  - RD: cs=1, a0=0, rd_n=0.
  - CAP: cs=0; `aux_result` <= `sec_dout`; `aux_ack` pulses for one clk, then IDLE.
- Latency: 6 cen edges from start to `aux_ack`.
- `aux_busy`=1 and `cpu_wait_n`=0 (whenever the CPU strobes the device) in every non-IDLE state.
- The CPU access completes after return to IDLE.
- `aux_req` still high at ack starts a new transaction on the next qualifying cen.
- Operand changes during busy are ignored.
- Expected result: (hi<<s | lo>>(8-s)) mod 256; s=0 gives hi.

Optional Feature:
- Macro: SEC_CTX_RESTORE_EN.
- Enabled:
  - Shadow registers capture CPU-side device state: last two a0=1 writes (sh_lo/sh_hi FIFO) and last a0=0 write (sh_shift). All reset to 0.
  - After CAP, states R_LO, R_HI, R_SH, R_SET replay the shadows with the same bus encoding, so CPU reads return the pre-transaction result.
  - `aux_ack` still pulses at CAP; `aux_busy` and the stall extend 4 more cen periods.
- Disabled: no shadows; device state after aux is the aux operands.

Decomposition:
- Package jtpopeye_sec_pkg: FSM state enum, bus-encoding constants (A0_DATA=1, A0_SHIFT=0), 10-cycle max transaction length constant.
- Sub-module: none required; the shifter itself stays a separate instance in the testbench.

Test Plan:
- Aux hi=A5, lo=3C, s=3, CPU idle -> `aux_ack` after 6 cen, `aux_result`=29, `cpu_wait_n` stays 1.
- Aux hi=5A, lo=FF, s=0 -> `aux_result`=5A.
- CPU write a0=0 issued during W_HI -> `cpu_wait_n`=0 until IDLE, then the write reaches the device unaltered.
- Same-cycle CPU access and `aux_req`, AUX_PRIO=0 -> CPU access passes through, aux starts on the first cen after the CPU strobes release.
- `rst` asserted in RD -> next clk all outputs at reset values, no `aux_ack`; a following request completes normally.
- With SEC_CTX_RESTORE_EN: CPU writes 11, 22, shift 4, then aux, then CPU read a0=0 -> 21 (same as before aux).
